// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Drives STALL/CLEAR of IF/ID, ID/EX, EX/MEM and MEM/WB plus PC hold.
// Resolves load-use, mul/div wait, data-memory wait, taken-branch and trap hazards.
// Keeps saturating counters of stall cycles and flush events.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_RUN    | normal issue; only single-cycle hazards are resolved
// S_MD_WAIT| mul/div op in flight; front end held until md_done
// S_FLUSH  | post-trap redirect; IF/ID kept cleared for FLUSH_CYCLES cycles
module pipe_hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_md_start,
    input  logic             md_done,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             trap,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_clr,
    output logic             idex_stall,
    output logic             idex_clr,
    output logic             exmem_stall,
    output logic             exmem_clr,
    output logic             memwb_stall,
    output logic             memwb_clr,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MD_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYCLES - 1);

    state_t        state, state_nxt;
    logic [FW-1:0] fcnt, fcnt_nxt;

    logic mem_wait;
    logic load_use;
    logic md_hold;
    logic br_act;

    assign mem_wait = mem_req & ~mem_ready;
    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));
    assign md_hold  = (state == S_MD_WAIT) & ~md_done;
    // A branch only redirects once nothing above it in priority holds the pipe.
    assign br_act   = ex_br_taken & ~trap & ~mem_wait & ~md_hold;
    assign md_busy  = (state == S_MD_WAIT);

    // State and flush down-counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Next-state logic; trap wins from every state and reloads the flush timer.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (trap) begin
            state_nxt = S_FLUSH;
            fcnt_nxt  = FLOAD;
        end else begin
            case (state)
                S_RUN: begin
                    if (ex_md_start && !mem_wait) state_nxt = S_MD_WAIT;
                end
                S_MD_WAIT: begin
                    if (md_done) state_nxt = S_RUN;
                end
                S_FLUSH: begin
                    if (fcnt == '0) state_nxt = S_RUN;
                    else            fcnt_nxt  = fcnt - FW'(1);
                end
                default: state_nxt = S_RUN;
            endcase
        end
    end

    // Stage control outputs, prioritised hazard resolution; all quiet during reset.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_clr    = 1'b0;
        idex_stall  = 1'b0;
        idex_clr    = 1'b0;
        exmem_stall = 1'b0;
        exmem_clr   = 1'b0;
        memwb_stall = 1'b0;
        memwb_clr   = 1'b0;
        if (!RST) begin
            if (trap) begin
                ifid_clr  = 1'b1;
                idex_clr  = 1'b1;
                exmem_clr = 1'b1;
            end else begin
                if (mem_wait) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    memwb_clr   = 1'b1;
                end else if (md_hold) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_stall = 1'b1;
                    exmem_clr  = 1'b1;
                end else if (ex_br_taken) begin
                    ifid_clr = 1'b1;
                    idex_clr = 1'b1;
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_clr   = 1'b1;
                end
                // Wrong-path fetches are dropped after a trap; clear beats stall.
                if (state == S_FLUSH) begin
                    ifid_clr   = 1'b1;
                    ifid_stall = 1'b0;
                end
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if ((trap || br_act) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;
    localparam int FC = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_rs1_used = 0, id_rs2_used = 0, ex_is_load = 0, ex_md_start = 0;
    logic          md_done = 0, ex_br_taken = 0, mem_req = 0, mem_ready = 0, trap = 0;
    logic          pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr;
    logic          exmem_stall, exmem_clr, memwb_stall, memwb_clr, md_busy;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: mul/div pending flag, flush cycles still to run, counters.
    bit m_md;
    int m_flush_left;
    int m_scnt, m_fcnt;

    pipe_hazard_ctrl #(.CNT_W(CW), .FLUSH_CYCLES(FC)) dut (
        .CLK(CLK), .RST(RST),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_md_start(ex_md_start), .md_done(md_done),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready), .trap(trap),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_clr(ifid_clr),
        .idex_stall(idex_stall), .idex_clr(idex_clr), .exmem_stall(exmem_stall),
        .exmem_clr(exmem_clr), .memwb_stall(memwb_stall), .memwb_clr(memwb_clr),
        .md_busy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    // Output vector order: pc,ifid_s,ifid_c,idex_s,idex_c,exmem_s,exmem_c,memwb_s,memwb_c,md_busy
    function automatic logic [9:0] obs_vec();
        return {pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr,
                exmem_stall, exmem_clr, memwb_stall, memwb_clr, md_busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_md = 0; m_flush_left = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; ex_rd = 0;
        ex_is_load = 0; ex_md_start = 0; md_done = 0; ex_br_taken = 0;
        mem_req = 0; mem_ready = 0; trap = 0;
    endtask

    // One clock: inputs already driven; check at negedge, then advance model and clock.
    task automatic cycle(input string tag);
        bit mw, lu, hold, fl, br;
        bit pc, ifs, ifc, ids, idc, exs, exc, mbs, mbc;
        logic [9:0] exp;
        @(negedge CLK);
        mw   = mem_req && !mem_ready;
        lu   = ex_is_load && ex_rd != 0 &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        hold = m_md && !md_done;
        fl   = m_flush_left > 0;
        {pc, ifs, ifc, ids, idc, exs, exc, mbs, mbc} = '0;
        br   = 0;
        if (trap) begin
            ifc = 1; idc = 1; exc = 1;
        end else begin
            if (mw)               begin pc = 1; ifs = 1; ids = 1; exs = 1; mbc = 1; end
            else if (hold)        begin pc = 1; ifs = 1; ids = 1; exc = 1; end
            else if (ex_br_taken) begin ifc = 1; idc = 1; br = 1; end
            else if (lu)          begin pc = 1; ifs = 1; idc = 1; end
            if (fl) begin ifc = 1; ifs = 0; end
        end
        exp = {pc, ifs, ifc, ids, idc, exs, exc, mbs, mbc, m_md};
        chk({tag, ".ctl"},   {22'd0, obs_vec()}, {22'd0, exp});
        chk({tag, ".scnt"},  {28'd0, stall_cnt}, m_scnt);
        chk({tag, ".fcnt"},  {28'd0, flush_cnt}, m_fcnt);
        if (pc && m_scnt < 15)                  m_scnt++;
        if ((trap || br) && m_fcnt < 15)        m_fcnt++;
        if (trap)              begin m_md = 0; m_flush_left = FC; end
        else if (fl)           m_flush_left--;
        else if (m_md)         begin if (md_done) m_md = 0; end
        else if (ex_md_start && !mw) m_md = 1;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst.ctl",  {22'd0, obs_vec()}, 32'd0);
        chk("rst.scnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst.fcnt", {28'd0, flush_cnt}, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        idle();
        // Reset held with hazards driven: outputs must stay quiet.
        trap = 1; mem_req = 1; ex_br_taken = 1;
        #2;
        chk("rst_hold.ctl", {22'd0, obs_vec()}, 32'd0);
        @(posedge CLK); #1;
        idle();
        do_reset();
        cycle("idle");

        // Load-use on rs1, then clean.
        ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        cycle("lu_rs1");
        idle(); cycle("lu_after");
        // Load to x0, and rs2 match that is not used.
        ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
        cycle("lu_x0");
        idle(); ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 0;
        cycle("lu_rs2_unused");
        id_rs2_used = 1; cycle("lu_rs2_used");
        idle();

        // Mul/div: start with md_done in entry cycle (ignored), done 4 cycles later.
        ex_md_start = 1; md_done = 1; cycle("md_start");
        idle();
        for (int i = 0; i < 3; i++) cycle("md_wait");
        md_done = 1; cycle("md_done");
        idle(); cycle("md_after");

        // mem_wait during MD_WAIT.
        ex_md_start = 1; cycle("md2_start");
        idle(); mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) cycle("md2_memwait");
        idle(); ex_br_taken = 1; cycle("md2_br_held");
        md_done = 1; cycle("md2_done_br");
        idle(); ex_br_taken = 1; cycle("br_released");
        idle();

        // md_start while memory waits is not accepted.
        ex_md_start = 1; mem_req = 1; cycle("md_start_memwait");
        idle(); cycle("md_not_entered");

        // Trap during MD_WAIT, then flush and a late md_done.
        ex_md_start = 1; cycle("md3_start");
        idle(); cycle("md3_wait");
        trap = 1; cycle("md3_trap");
        idle(); cycle("flush1");
        ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1; cycle("flush2_lu");
        idle(); md_done = 1; cycle("late_md_done");
        idle(); cycle("post_flush");

        // Trap with branch same cycle, retrap during flush, branch in flush.
        trap = 1; ex_br_taken = 1; cycle("trap_br");
        trap = 0; ex_md_start = 1; mem_req = 1; cycle("flush_memwait");
        idle(); trap = 1; cycle("retrap");
        idle(); ex_br_taken = 1; cycle("flush_br");
        idle(); cycle("flush_end");
        cycle("run");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            ex_is_load  = ($urandom_range(0, 2) == 0);
            ex_md_start = ($urandom_range(0, 5) == 0);
            md_done     = ($urandom_range(0, 3) == 0);
            ex_br_taken = ($urandom_range(0, 5) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            mem_ready   = 1'($urandom_range(0, 1));
            trap        = ($urandom_range(0, 15) == 0);
            cycle("rand");
        end
        idle();

        // Saturation of stall_cnt at 15, then async reset mid-stall.
        do_reset();
        ex_is_load = 1; ex_rd = 9; id_rs2 = 9; id_rs2_used = 1;
        for (int i = 0; i < 17; i++) cycle("sat");
        chk("sat.value", {28'd0, stall_cnt}, 32'd15);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst.ctl",  {22'd0, obs_vec()}, 32'd0);
        chk("async_rst.scnt", {28'd0, stall_cnt}, 32'd0);
        chk("async_rst.fcnt", {28'd0, flush_cnt}, 32'd0);
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
        cycle("after_rst_lu");
        idle(); cycle("after_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
